// File: rtl/display_bin_7seg_pkg.sv
// ---------------------------------------------------------------------------
// display_bin_7seg_pkg
// Shared definitions for the binary-to-decimal 7-segment display block:
// active-low segment codes for the decimal digits, anode patterns, the
// digit-slot state type, and a helper that splits a 0..15 value into
// decimal tens/ones digits.
// ---------------------------------------------------------------------------
package display_bin_7seg_pkg;

    // Segment codes are {g,f,e,d,c,b,a}, active-low (0 = lit)
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Anode patterns, active-low; bit 0 is the rightmost digit
    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;

    // Four equal time slots; only the first two drive a digit, which keeps
    // each digit at a constant quarter duty cycle
    typedef enum logic [1:0] {
        S0_ONES = 2'd0,
        S1_TENS = 2'd1,
        S2_IDLE = 2'd2,
        S3_IDLE = 2'd3
    } slot_t;

    typedef struct packed {
        logic       tens;
        logic [3:0] ones;
    } digits_t;

    // Advance to the following slot, wrapping after the last idle slot
    function automatic slot_t nextSlot(input slot_t s);
        slot_t n;
        n = S0_ONES;
        case (s)
            S0_ONES: n = S1_TENS;
            S1_TENS: n = S2_IDLE;
            S2_IDLE: n = S3_IDLE;
            default: n = S0_ONES;
        endcase
        return n;
    endfunction

    // A 4-bit value never exceeds 15, so the tens digit is a single bit
    function automatic digits_t splitDigits(input logic [3:0] value);
        digits_t d;
        d.tens = (value >= 4'd10);
        d.ones = d.tens ? (value - 4'd10) : value;
        return d;
    endfunction

endpackage

// File: rtl/display_bin_7seg_if.sv
// ---------------------------------------------------------------------------
// display_bin_7seg_if
// Bundles the decoder-facing value input and the display pin outputs.
//   bin : 4-bit binary value from the Gray decoder
//   seg : segments {g,f,e,d,c,b,a}, active-low
//   an  : digit anodes, active-low, an[0] = rightmost digit
//   dp  : decimal point, active-low (held off)
// master: the side producing bin and watching the pins
// slave : the display driver
// ---------------------------------------------------------------------------
interface display_bin_7seg_if;

    logic [3:0] bin;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (
        output bin,
        input  seg,
        input  an,
        input  dp
    );

    modport slave (
        input  bin,
        output seg,
        output an,
        output dp
    );

endinterface

// File: rtl/display_bin_7seg_seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Combinational decimal digit to active-low 7-segment pattern.
//   i_digit : digit 0..9 (codes above 9 give a dark display)
//   o_seg   : segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module seg7_decoder
    import display_bin_7seg_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Standard digit table; anything outside 0..9 stays dark rather than
    // showing a misleading pattern
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_bin_7seg.sv
// ---------------------------------------------------------------------------
// display_bin_7seg
// Shows a 4-bit binary value as a decimal number 0..15 on a 4-digit
// common-anode 7-segment display. The input is sampled at a slow rate so
// the digits do not flicker, then the two used digits are time-multiplexed
// with a dark gap at the start of every slot to suppress ghosting.
//   clk   : system clock
//   rst_n : asynchronous reset, active-low
//   disp  : slave side of display_bin_7seg_if (bin in; seg/an/dp out)
// ---------------------------------------------------------------------------
module display_bin_7seg
    import display_bin_7seg_pkg::*;
#(
    parameter int unsigned SAMPLE_LIMIT  = 24_999_999,
    parameter int unsigned REFRESH_LIMIT = 99_999,
    parameter int unsigned BLANK_CYCLES  = 1_000,
    parameter bit          BLANK_LEADING = 1'b1
)(
    input  logic              clk,
    input  logic              rst_n,
    display_bin_7seg_if.slave disp
);

    localparam int SAMPLE_W  = (SAMPLE_LIMIT  > 0) ? $clog2(SAMPLE_LIMIT  + 1) : 1;
    localparam int REFRESH_W = (REFRESH_LIMIT > 0) ? $clog2(REFRESH_LIMIT + 1) : 1;

    logic [SAMPLE_W-1:0]  r_sampleCnt;
    logic [3:0]           r_shown;
    logic [REFRESH_W-1:0] r_refreshCnt;
    slot_t                r_slot;
    logic [6:0]           r_seg;
    logic [3:0]           r_an;

    digits_t              w_digits;
    logic                 w_blank;
    logic [3:0]           w_anNext;
    logic [3:0]           w_digit;
    logic [6:0]           w_segDigit;

    // Slow sampler: the displayed value only changes once per sample period,
    // captured on the same edge the counter wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sampleCnt <= '0;
            r_shown     <= 4'd0;
        end else if (r_sampleCnt == SAMPLE_W'(SAMPLE_LIMIT)) begin
            r_sampleCnt <= '0;
            r_shown     <= disp.bin;
        end else begin
            r_sampleCnt <= r_sampleCnt + SAMPLE_W'(1);
        end
    end

    assign w_digits = splitDigits(r_shown);
    assign w_blank  = (r_refreshCnt < REFRESH_W'(BLANK_CYCLES));

    // Pick the anode and digit for the current slot. A slot boundary always
    // falls inside the dark window, so a freshly captured value never
    // appears half-way through a digit's on-time.
    always_comb begin
        w_anNext = AN_OFF;
        w_digit  = 4'd0;
        if (!w_blank) begin
            case (r_slot)
                S0_ONES: begin
                    w_anNext = AN_ONES;
                    w_digit  = w_digits.ones;
                end
                S1_TENS: begin
                    if (w_digits.tens || !BLANK_LEADING) begin
                        w_anNext = AN_TENS;
                        w_digit  = {3'b000, w_digits.tens};
                    end
                end
                default: begin
                    w_anNext = AN_OFF;
                end
            endcase
        end
    end

    seg7_decoder u_seg7 (
        .i_digit (w_digit),
        .o_seg   (w_segDigit)
    );

    // Scan state machine: slot timer, slot sequencing and the registered pin
    // drivers. Reset darkens the pins immediately and restarts at the ones
    // slot inside its dark window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refreshCnt <= '0;
            r_slot       <= S0_ONES;
            r_an         <= AN_OFF;
            r_seg        <= SEG_BLANK;
        end else begin
            if (r_refreshCnt == REFRESH_W'(REFRESH_LIMIT)) begin
                r_refreshCnt <= '0;
                r_slot       <= nextSlot(r_slot);
            end else begin
                r_refreshCnt <= r_refreshCnt + REFRESH_W'(1);
            end
            r_an  <= w_anNext;
            r_seg <= (w_anNext == AN_OFF) ? SEG_BLANK : w_segDigit;
        end
    end

    assign disp.seg = r_seg;
    assign disp.an  = r_an;
    assign disp.dp  = 1'b1;

endmodule
